router_fsm_nch: RTL and testbench



---
 rtl/router_fsm_nch.sv | 180 ++++++++++++++++++
 tb/tb_router_fsm_nch.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/router_fsm_nch.sv
// router_fsm_nch
//   Control FSM for the 1xN router. Sequences header decode, first-data
//   load, payload load, FIFO-full stall, parity load and parity check
//   for NUM_PORTS output FIFOs. It also handles three extra cases:
//     - headers addressed to a port that does not exist are dropped,
//     - waiting for a busy FIFO to drain is bounded by WAIT_TIMEOUT,
//     - only the soft reset of the latched port is honoured.
//   All decode outputs are registered. They are computed from the next
//   state, so each one lines up with the state register.
//
// Ports
//   clock, resetn      rising-edge clock, async active-low reset
//   pkt_valid          source byte valid
//   data_in            header address bits
//   parity_done        parity byte written by the register block
//   low_pkt_valid      pkt_valid fell while stalled on full
//   fifo_full          full flag of the addressed FIFO
//   fifo_empty         per-port empty flags
//   soft_reset         per-port read-timeout soft resets
//   detect_add..drop_state  state decodes
//   write_enb_reg      FIFO write enable
//   busy               backpressure to the source
//   addr_q             latched destination address
//   bad_addr           1-cycle pulse, header addressed an illegal port
//   timeout_err        1-cycle pulse, wait-till-empty timed out
module router_fsm_nch #(
  parameter int NUM_PORTS    = 3,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 30
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 rst_int_reg,
  output logic                 write_enb_reg,
  output logic                 busy,
  output logic                 drop_state,
  output logic [ADDR_W-1:0]    addr_q,
  output logic                 bad_addr,
  output logic                 timeout_err
);

  localparam int NSLOT = 2**ADDR_W;
  localparam int CW    = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [ADDR_W:0] NP    = NUM_PORTS[ADDR_W:0];
  localparam logic [CW-1:0]   TO_M1 = CW'(WAIT_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_DECODE,
    S_LFD,
    S_LD,
    S_LP,
    S_FULL,
    S_LAF,
    S_WAIT,
    S_CPE,
    S_DROP
  } state_t;

  state_t          r_state;
  state_t          w_nxt;
  logic [CW-1:0]   r_cnt;
  logic            w_bad;
  logic            w_to;

  // Flags widened to the full address space so any address indexes
  // safely; slots past NUM_PORTS read as 0.
  logic [NSLOT-1:0] w_emp_pad;
  logic [NSLOT-1:0] w_sr_pad;
  logic             w_emp_in;
  logic             w_emp_q;
  logic             w_sr;
  logic             w_addr_bad;

  always_comb begin
    w_emp_pad                = '0;
    w_emp_pad[NUM_PORTS-1:0] = fifo_empty;
    w_sr_pad                 = '0;
    w_sr_pad[NUM_PORTS-1:0]  = soft_reset;
  end

  assign w_emp_in   = w_emp_pad[data_in];
  assign w_emp_q    = w_emp_pad[addr_q];
  assign w_sr       = w_sr_pad[addr_q];
  assign w_addr_bad = ({1'b0, data_in} >= NP);

  always_comb begin
    w_nxt = r_state;
    w_bad = 1'b0;
    w_to  = 1'b0;
    // Soft reset of the latched port overrides every transition
    if (r_state != S_DECODE && w_sr) begin
      w_nxt = S_DECODE;
    end else begin
      case (r_state)
        S_DECODE: if (pkt_valid) begin
          if (w_addr_bad) begin
            w_nxt = S_DROP;
            w_bad = 1'b1;
          end else if (w_emp_in) begin
            w_nxt = S_LFD;
          end else begin
            w_nxt = S_WAIT;
          end
        end
        S_LFD:  w_nxt = S_LD;
        S_LD: begin
          if (fifo_full)       w_nxt = S_FULL;
          else if (!pkt_valid) w_nxt = S_LP;
        end
        S_LP:   w_nxt = S_CPE;
        S_FULL: if (!fifo_full) w_nxt = S_LAF;
        S_LAF: begin
          if (parity_done)        w_nxt = S_DECODE;
          else if (low_pkt_valid) w_nxt = S_LP;
          else                    w_nxt = S_LD;
        end
        S_CPE:  w_nxt = fifo_full ? S_FULL : S_DECODE;
        S_WAIT: begin
          // A drained FIFO wins over a timeout in the same cycle
          if (w_emp_q) begin
            w_nxt = S_LFD;
          end else if (r_cnt == TO_M1) begin
            w_nxt = S_DROP;
            w_to  = 1'b1;
          end
        end
        S_DROP: if (!pkt_valid) w_nxt = S_DECODE;
        default: w_nxt = S_DECODE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_DECODE;
      r_cnt         <= '0;
      addr_q        <= '0;
      bad_addr      <= 1'b0;
      timeout_err   <= 1'b0;
      detect_add    <= 1'b1;
      lfd_state     <= 1'b0;
      ld_state      <= 1'b0;
      laf_state     <= 1'b0;
      full_state    <= 1'b0;
      rst_int_reg   <= 1'b0;
      drop_state    <= 1'b0;
      write_enb_reg <= 1'b0;
      busy          <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (r_state == S_DECODE && pkt_valid) addr_q <= data_in;
      // Counter only runs while staying in WAIT, so it is 0 on entry
      r_cnt         <= (r_state == S_WAIT && w_nxt == S_WAIT) ? r_cnt + 1'b1 : '0;
      bad_addr      <= w_bad;
      timeout_err   <= w_to;
      detect_add    <= (w_nxt == S_DECODE);
      lfd_state     <= (w_nxt == S_LFD);
      ld_state      <= (w_nxt == S_LD);
      laf_state     <= (w_nxt == S_LAF);
      full_state    <= (w_nxt == S_FULL);
      rst_int_reg   <= (w_nxt == S_CPE);
      drop_state    <= (w_nxt == S_DROP);
      write_enb_reg <= (w_nxt == S_LD) || (w_nxt == S_LP) || (w_nxt == S_LAF);
      busy          <= !((w_nxt == S_DECODE) || (w_nxt == S_LD) || (w_nxt == S_DROP));
    end
  end

endmodule

// File: tb/tb_router_fsm_nch.sv
module tb_router_fsm_nch;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       pkt_valid = 1'b0;
  logic [1:0] data_in = '0;
  logic       parity_done = 1'b0;
  logic       low_pkt_valid = 1'b0;
  logic       fifo_full = 1'b0;
  logic [2:0] fifo_empty = 3'b111;
  logic [2:0] soft_reset = '0;
  logic detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic write_enb_reg, busy, drop_state, bad_addr, timeout_err;
  logic [1:0] addr_q;

  router_fsm_nch #(.NUM_PORTS(3), .ADDR_W(2), .WAIT_TIMEOUT(4)) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .write_enb_reg(write_enb_reg), .busy(busy), .drop_state(drop_state),
    .addr_q(addr_q), .bad_addr(bad_addr), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  // Observed decode vector: {detect,lfd,ld,laf,full,rst_int,drop,wen,busy}
  logic [8:0] obs;
  assign obs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                rst_int_reg, drop_state, write_enb_reg, busy};

  localparam logic [8:0] DEC  = 9'b100000000;
  localparam logic [8:0] LFD  = 9'b010000001;
  localparam logic [8:0] LD   = 9'b001000010;
  localparam logic [8:0] LAF  = 9'b000100011;
  localparam logic [8:0] FULL = 9'b000010001;
  localparam logic [8:0] CPE  = 9'b000001001;
  localparam logic [8:0] DROP = 9'b000000100;
  localparam logic [8:0] LP   = 9'b000000011;
  localparam logic [8:0] WT   = 9'b000000001;

  int n_vec  = 0;
  int n_miss = 0;
  int wen_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #12 resetn = 1'b1;
    #1;
    chk("rst_state", 32'(obs), 32'(DEC));
    chk("rst_addr", 32'(addr_q), 0);
    chk("rst_pulses", 32'({bad_addr, timeout_err}), 0);

    // Normal packet to port 1, 4-byte payload
    @(negedge clock);
    data_in = 2'd1; pkt_valid = 1'b1; fifo_empty = 3'b111;
    step(); chk("n_lfd", 32'(obs), 32'(LFD));
    wen_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(); chk("n_ld", 32'(obs), 32'(LD));
      wen_cnt += int'(write_enb_reg);
    end
    pkt_valid = 1'b0;
    step(); chk("n_lp", 32'(obs), 32'(LP)); wen_cnt += int'(write_enb_reg);
    step(); chk("n_cpe", 32'(obs), 32'(CPE)); wen_cnt += int'(write_enb_reg);
    step(); chk("n_dec", 32'(obs), 32'(DEC));
    chk("n_wen_cnt", 32'(wen_cnt), 5);
    chk("n_addr", 32'(addr_q), 1);

    // Illegal address 3, 6-byte payload consumed in DROP
    data_in = 2'd3; pkt_valid = 1'b1;
    step(); chk("d_drop", 32'(obs), 32'(DROP));
    chk("d_bad_hi", 32'(bad_addr), 1);
    chk("d_addr", 32'(addr_q), 3);
    for (int i = 0; i < 5; i++) begin
      step(); chk("d_hold", 32'({obs, bad_addr}), 32'({DROP, 1'b0}));
    end
    pkt_valid = 1'b0;
    step(); chk("d_dec", 32'(obs), 32'(DEC));

    // Wait timeout on port 2
    data_in = 2'd2; pkt_valid = 1'b1; fifo_empty = 3'b011;
    step(); chk("w_wait1", 32'(obs), 32'(WT));
    pkt_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk("w_waitn", 32'({obs, timeout_err}), 32'({WT, 1'b0}));
    end
    step(); chk("w_drop", 32'(obs), 32'(DROP));
    chk("w_to_hi", 32'({timeout_err, bad_addr}), 32'(2'b10));
    step(); chk("w_dec", 32'(obs), 32'(DEC));
    chk("w_to_lo", 32'(timeout_err), 0);

    // Wait on port 2, FIFO drains on the 4th wait cycle
    pkt_valid = 1'b1;
    step(); chk("e_wait1", 32'(obs), 32'(WT));
    for (int i = 0; i < 3; i++) begin
      step(); chk("e_waitn", 32'(obs), 32'(WT));
    end
    fifo_empty = 3'b111;
    step(); chk("e_lfd", 32'({obs, timeout_err}), 32'({LFD, 1'b0}));

    // Full stall for 3 cycles, exit through low_pkt_valid
    step(); chk("f_ld", 32'(obs), 32'(LD));
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk("f_full", 32'(obs), 32'(FULL));
    end
    fifo_full = 1'b0;
    step(); chk("f_laf", 32'(obs), 32'(LAF));
    low_pkt_valid = 1'b1; pkt_valid = 1'b0;
    step(); chk("f_lp", 32'(obs), 32'(LP));
    low_pkt_valid = 1'b0;
    step(); chk("f_cpe", 32'(obs), 32'(CPE));
    step(); chk("f_dec", 32'(obs), 32'(DEC));

    // Full stall, exit through parity_done
    data_in = 2'd0; pkt_valid = 1'b1;
    step(); chk("p_lfd", 32'(obs), 32'(LFD));
    step(); chk("p_ld", 32'(obs), 32'(LD));
    fifo_full = 1'b1;
    step(); chk("p_full", 32'(obs), 32'(FULL));
    fifo_full = 1'b0;
    step(); chk("p_laf", 32'(obs), 32'(LAF));
    parity_done = 1'b1; pkt_valid = 1'b0;
    step(); chk("p_dec", 32'(obs), 32'(DEC));
    parity_done = 1'b0;

    // Soft reset qualification on port 0
    pkt_valid = 1'b1; data_in = 2'd0;
    step(); chk("s_lfd", 32'(obs), 32'(LFD));
    step(); chk("s_ld", 32'(obs), 32'(LD));
    soft_reset = 3'b010;
    step(); chk("s_other", 32'(obs), 32'(LD));
    soft_reset = 3'b001;
    step(); chk("s_own", 32'(obs), 32'(DEC));
    soft_reset = 3'b000;
    chk("s_addr", 32'(addr_q), 0);

    // Async reset mid-cycle while in LOAD_AFTER_FULL
    step(); chk("r_lfd", 32'(obs), 32'(LFD));
    step(); chk("r_ld", 32'(obs), 32'(LD));
    fifo_full = 1'b1;
    step(); chk("r_full", 32'(obs), 32'(FULL));
    fifo_full = 1'b0; data_in = 2'd2;
    step(); chk("r_laf", 32'(obs), 32'(LAF));
    #2 resetn = 1'b0;
    #1;
    chk("r_async", 32'(obs), 32'(DEC));
    chk("r_async_q", 32'({addr_q, bad_addr, timeout_err}), 0);
    pkt_valid = 1'b0;
    #3 resetn = 1'b1;
    step(); chk("r_after", 32'(obs), 32'(DEC));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
